dcache_wb: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache for the MEM stage, with line-wide refill and writeback to a backing memory over a req/ready handshake.
- Supports the RV32 load/store widths LB/LH/LW/LBU/LHU/SB/SH/SW at any byte offset inside a line.
- Asserts stall to freeze the pipeline on misses and during a software-triggered flush of all dirty lines.

---
 rtl/dcache_wb.sv | 241 ++++++++++++++++++++++++
 tb/tb_dcache_wb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Full-line refill and writeback to a backing memory over a req/ready handshake,
// plus a software flush that writes back every dirty line in ascending index order.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   MemRead, MemWrite          load / store request (store wins if both are high)
//   alu_result_M, rs2_rdata_M  byte address, right-aligned store data
//   funct3                     RV32 width code (B, H, W, BU, HU)
//   flush                      level request to write back all dirty lines
//   mem_rdata                  extended load result (0 when there is no load hit)
//   stall                      freeze the pipeline; the request must stay stable
//   misalign                   H/W access not naturally aligned (address is forced aligned)
//   flush_done                 one-cycle pulse at the end of a flush
//   mem_req, mem_we, mem_addr, mem_wdata   backing-memory request (line granularity)
//   mem_ready, mem_rdata_line              backing-memory completion and fill data
module dcache_wb #(
  parameter int ADDR_WIDTH     = 16,
  parameter int SET_NUM        = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int LINE_W        = 32 * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           alu_result_M,
  input  logic [31:0]           rs2_rdata_M,
  input  logic [2:0]            funct3,
  input  logic                  flush,
  output logic [31:0]           mem_rdata,
  output logic                  stall,
  output logic                  misalign,
  output logic                  flush_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_W-1:0]     mem_rdata_line
);

  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int OFF_W  = $clog2(4 * WORDS_PER_LINE);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [SET_NUM-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [SET_NUM];
  logic [LINE_W-1:0] data_q [SET_NUM];

  // Upper address bits beyond ADDR_WIDTH are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^alu_result_M[31:ADDR_WIDTH];

  // Request decode; the address is forced to natural alignment for H and W.
  logic                  is_half, is_word, req;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WSEL_W-1:0]     word_sel;
  logic [1:0]            byte_off;

  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);
  assign req     = MemRead | MemWrite;

  always_comb begin
    eff_addr = alu_result_M[ADDR_WIDTH-1:0];
    if (is_half) eff_addr[0]   = 1'b0;
    if (is_word) eff_addr[1:0] = 2'b00;
  end

  assign req_tag  = eff_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = eff_addr[OFF_W +: IDX_W];
  assign word_sel = eff_addr[2 +: WSEL_W];
  assign byte_off = eff_addr[1:0];

  logic hit, load_hit, store_hit;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign load_hit  = (state_q == S_IDLE) && !flush && MemRead && !MemWrite && hit;
  assign store_hit = (state_q == S_IDLE) && !flush && MemWrite && hit;

  // Load extraction and sign/zero extension.
  logic [31:0] rd_word, rd_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_word = data_q[req_idx][word_sel*32 +: 32];
    rd_byte = rd_word[byte_off*8 +: 8];
    rd_half = rd_word[byte_off[1]*16 +: 16];
    case (funct3)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = rd_word;
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = 32'h0;
    endcase
  end

  // Store merge: replicating the data across the word means only the byte mask
  // has to move with the offset.
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;
  logic [LINE_W-1:0] merged_line;

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << byte_off;
        wr_data = {4{rs2_rdata_M[7:0]}};
      end
      2'b01: begin
        wr_mask = 4'b0011 << byte_off;
        wr_data = {2{rs2_rdata_M[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_data = rs2_rdata_M;
      end
    endcase
    merged_line = data_q[req_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_mask[b]) merged_line[word_sel*32 + b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  // FSM next-state and outputs.
  logic                  stall_c, req_c, we_c, flush_done_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [LINE_W-1:0]     wdata_c;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    stall_c      = 1'b0;
    req_c        = 1'b0;
    we_c         = 1'b0;
    flush_done_c = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          stall_c     = 1'b1;
          flush_cnt_d = '0;
          state_d     = S_FLUSH_SCAN;
        end else if (req && !hit) begin
          stall_c = 1'b1;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
        wdata_c = data_q[req_idx];
        if (mem_ready) state_d = S_FILL;
      end
      S_FILL: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        addr_c  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ready) state_d = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        stall_c = 1'b1;
        if (valid_q[flush_cnt_q] && dirty_q[flush_cnt_q]) begin
          state_d = S_FLUSH_WB;
        end else if (flush_cnt_q == IDX_W'(SET_NUM - 1)) begin
          flush_done_c = 1'b1;
          state_d      = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = {tag_q[flush_cnt_q], flush_cnt_q, {OFF_W{1'b0}}};
        wdata_c = data_q[flush_cnt_q];
        if (mem_ready) state_d = S_FLUSH_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is forced low while reset is held, abandoning any handshake.
  assign stall      = rst_n & stall_c;
  assign mem_req    = rst_n & req_c;
  assign mem_we     = rst_n & we_c;
  assign flush_done = rst_n & flush_done_c;
  assign misalign   = rst_n & req & ((is_half & alu_result_M[0]) |
                                     (is_word & (alu_result_M[1:0] != 2'b00)));
  assign mem_addr   = rst_n ? addr_c : '0;
  assign mem_wdata  = rst_n ? wdata_c : '0;
  assign mem_rdata  = (rst_n && load_hit) ? rd_ext : 32'h0;

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (store_hit) dirty_q[req_idx] <= 1'b1;
      if (state_q == S_WB && mem_ready) dirty_q[req_idx] <= 1'b0;
      if (state_q == S_FLUSH_WB && mem_ready) dirty_q[flush_cnt_q] <= 1'b0;
      if (state_q == S_FILL && mem_ready) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone decide whether
  // their contents mean anything, which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (store_hit) data_q[req_idx] <= merged_line;
    if (state_q == S_FILL && mem_ready) begin
      data_q[req_idx] <= mem_rdata_line;
      tag_q[req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: table-driven load/store vectors, a backing
// memory model with programmable wait states, and a scoreboard of expected
// line transactions that is compared at every completed handshake.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         MemRead, MemWrite, flush;
  logic [31:0]  alu_result_M, rs2_rdata_M;
  logic [2:0]   funct3;
  logic [31:0]  mem_rdata;
  logic         stall, misalign, flush_done;
  logic         mem_req, mem_we, mem_ready;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata_line;

  dcache_wb dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .alu_result_M(alu_result_M), .rs2_rdata_M(rs2_rdata_M), .funct3(funct3),
    .flush(flush), .mem_rdata(mem_rdata), .stall(stall), .misalign(misalign),
    .flush_done(flush_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata_line(mem_rdata_line)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Backing memory model and scoreboard of expected line transactions.
  typedef struct {
    logic         we;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t         exp_q[$];
  logic [127:0] mem [4096];
  int           wait_cycles = 0;
  int           wait_cnt    = 0;
  int           hs_cnt      = 0;

  initial begin
    mem_ready      = 1'b0;
    mem_rdata_line = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (wait_cnt < wait_cycles) begin
          wait_cnt++;
          mem_ready = 1'b0;
        end else begin
          txn_t t;
          wait_cnt  = 0;
          mem_ready = 1'b1;
          hs_cnt++;
          if (mem_we) mem[mem_addr[15:4]] = mem_wdata;
          else        mem_rdata_line = mem[mem_addr[15:4]];
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected mem txn: got we=%0b addr=%0h, none required",
                     mem_we, mem_addr);
          end else begin
            t = exp_q.pop_front();
            check("txn we", 128'(mem_we), 128'(t.we));
            check("txn addr", 128'(mem_addr), 128'(t.addr));
            if (t.we) check("txn wdata", mem_wdata, t.wdata);
          end
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Issue one access just after a posedge; returns the load data and misalign
  // sampled in the first non-stalled cycle and the number of stalled cycles.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3,
                           output logic [31:0] rdata, output logic mis, output int stalls);
    bit done = 0;
    MemRead = rd; MemWrite = wr; alu_result_M = a; rs2_rdata_M = d; funct3 = f3;
    stalls = 0; rdata = '0; mis = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall) begin
        rdata = mem_rdata;
        mis   = misalign;
        done  = 1;
        break;
      end
      stalls++;
    end
    if (!done) stalls = 9999;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata;
    logic        mis;
    int          stalls, pulses, stall_lo, hs_before;
    bit          done;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 128'hDDDDDDDD_CCCCCCCC_8899AABB_00000000;
    mem[12'h020] = 128'h44444444_33333333_22222222_11111111;

    // Reset: outputs stay 0 even with a misaligned miss presented.
    rst_n = 1'b0; flush = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; alu_result_M = 32'h0106; rs2_rdata_M = '0; funct3 = 3'b010;
    repeat (2) @(negedge clk);
    check("reset stall", 128'(stall), 0);
    check("reset mem_req", 128'(mem_req), 0);
    check("reset misalign", 128'(misalign), 0);
    check("reset mem_rdata", 128'(mem_rdata), 0);
    check("reset flush_done", 128'(flush_done), 0);
    MemRead = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold load miss with three wait states.
    wait_cycles = 3;
    exp_q.push_back('{1'b0, 16'h0100, 128'h0});
    do_access(1'b1, 1'b0, 32'h0104, 32'h0, 3'b010, rdata, mis, stalls);
    check("cold LW stalls", 128'(stalls), 5);
    check("cold LW rdata", 128'(rdata), 128'h8899AABB);

    // Hits on the filled line, then store merges and read-back.
    vecs.push_back('{1'b1, 1'b0, 32'h0107, 32'h0, 3'b000, 32'hFFFFFF88, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0107, 32'h0, 3'b100, 32'h00000088, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0106, 32'h0, 3'b001, 32'hFFFF8899, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0106, 32'h0, 3'b101, 32'h00008899, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0106, 32'h0, 3'b010, 32'h8899AABB, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h010C, 32'h0, 3'b000, 32'hFFFFFFDD, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0105, 32'hEE, 3'b000, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0102, 32'h1234, 3'b001, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0104, 32'h0, 3'b010, 32'h8899EEBB, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0100, 32'h0, 3'b010, 32'h12340000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0103, 32'h0, 3'b101, 32'h00001234, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h0108, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0108, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0});
    foreach (vecs[i]) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                rdata, mis, stalls);
      check($sformatf("vec%0d rdata", i), 128'(rdata), 128'(vecs[i].exp_rdata));
      check($sformatf("vec%0d misalign", i), 128'(mis), 128'(vecs[i].exp_mis));
      check($sformatf("vec%0d stalls", i), 128'(stalls), 0);
    end

    // Dirty conflict miss: writeback of the victim, then fill, then hit.
    wait_cycles = 1;
    exp_q.push_back('{1'b1, 16'h0100, 128'hDDDDDDDD_CAFEF00D_8899EEBB_12340000});
    exp_q.push_back('{1'b0, 16'h0200, 128'h0});
    do_access(1'b1, 1'b0, 32'h0204, 32'h0, 3'b010, rdata, mis, stalls);
    check("dirty miss stalls", 128'(stalls), 5);
    check("dirty miss rdata", 128'(rdata), 128'h22222222);

    // Dirty sets 2 and 5, then flush.
    wait_cycles = 0;
    exp_q.push_back('{1'b0, 16'h0320, 128'h0});
    do_access(1'b0, 1'b1, 32'h0320, 32'h11112222, 3'b010, rdata, mis, stalls);
    check("set2 store stalls", 128'(stalls), 2);
    exp_q.push_back('{1'b0, 16'h0350, 128'h0});
    do_access(1'b0, 1'b1, 32'h0354, 32'h33334444, 3'b010, rdata, mis, stalls);
    check("set5 store stalls", 128'(stalls), 2);

    exp_q.push_back('{1'b1, 16'h0320, {96'h0, 32'h11112222}});
    exp_q.push_back('{1'b1, 16'h0350, {64'h0, 32'h33334444, 32'h0}});
    hs_before = hs_cnt; pulses = 0; stall_lo = 0; done = 0;
    flush = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall) stall_lo++;
      if (flush_done) begin
        pulses++;
        done = 1;
        break;
      end
    end
    @(posedge clk); #1 flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (flush_done) pulses++;
    end
    check("flush completed", 128'(done), 1);
    check("flush_done pulses", 128'(pulses), 1);
    check("flush stall low cycles", 128'(stall_lo), 0);
    check("flush writebacks", 128'(hs_cnt - hs_before), 2);
    check("post-flush stall", 128'(stall), 0);
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, 32'h0324, 32'h55, 3'b010, rdata, mis, stalls);
    check("re-store set2 stalls", 128'(stalls), 0);
    do_access(1'b1, 1'b0, 32'h0324, 32'h0, 3'b010, rdata, mis, stalls);
    check("re-load set2 rdata", 128'(rdata), 128'h55);

    // Reset in the middle of a fill abandons the handshake.
    wait_cycles = 8;
    MemRead = 1'b1; alu_result_M = 32'h0104; funct3 = 3'b010;
    @(negedge clk);
    @(negedge clk);
    check("mid-fill mem_req", 128'(mem_req), 1);
    check("mid-fill mem_addr", 128'(mem_addr), 128'h0100);
    #1 rst_n = 1'b0;
    #1;
    check("reset mem_req drop", 128'(mem_req), 0);
    check("reset stall drop", 128'(stall), 0);
    MemRead = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    wait_cycles = 1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 16'h0100, 128'h0});
    do_access(1'b1, 1'b0, 32'h0104, 32'h0, 3'b010, rdata, mis, stalls);
    check("refill stalls", 128'(stalls), 3);
    check("refill rdata", 128'(rdata), 128'h8899EEBB);

    check("scoreboard drained", 128'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
